// File: rtl/pipe_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
package pipe_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int ARB_BEAT_CNT_W = 8;

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Producer/consumer bundle around the arbiter. The slave modport is the arbiter's view.
// The master modport is the view of the surrounding pipeline (producers plus consumer).
interface pipe_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;
  logic                      busy;
  logic [SRC_W-1:0]          grant_id;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, busy, grant_id
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy, grant_id
  );

endinterface

// File: rtl/pipe_rr_arbiter_pick.sv
// Rotating-priority picker: returns the first set request strictly after 'last',
// wrapping from NUM_REQ-1 to 0. The 'last' index itself has the lowest priority.
module pipe_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic               any_valid,
  output logic [SRC_W-1:0]   pick
);

  int idx;

  // Scan offsets from farthest to nearest, so the nearest set request is the last one written.
  always_comb begin
    any_valid = 1'b0;
    pick      = last;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        any_valid = 1'b1;
        pick      = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin N:1 beat arbiter with a bounded burst length and a single registered output stage.
// Each grant is preceded by one IDLE cycle, and that cycle is where the rotation happens.
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  pipe_rr_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [SRC_W-1:0]          grant_q, grant_d, pick;
  logic [ARB_BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                      any_valid, can_load, accept;
  logic [NUM_REQ-1:0]        ready;
  logic                      out_valid_q;
  logic [DATA_W-1:0]         out_data_q;
  logic [SRC_W-1:0]          out_src_q;

  pipe_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (bus.req_valid),
    .last      (grant_q),
    .any_valid (any_valid),
    .pick      (pick)
  );

  // The output slot is free when it is empty or when it is being drained this cycle.
  assign can_load = !out_valid_q || bus.out_ready;
  assign accept   = (state_q == ARB_GRANT) && bus.req_valid[grant_q] && can_load;

  // Only the granted producer sees ready, and only when the output slot can take a beat.
  always_comb begin
    ready = '0;
    if (state_q == ARB_GRANT && can_load) ready[grant_q] = 1'b1;
  end

  // State, grant and burst counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= SRC_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: rotate in IDLE. Leave GRANT when the burst is exhausted or the owner goes idle.
  // Consumer stalls keep the grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          if (cnt_q == ARB_BEAT_CNT_W'(MAX_BURST - 1)) begin
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!bus.req_valid[grant_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output stage: load on accept. Clear on drain with no refill. Otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
      out_src_q   <= grant_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q == ARB_GRANT);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter and its picker. It covers picker vectors, directed corner sequences,
// and random traffic checked against a producer/scoreboard model.
module tb_pipe_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int MAXB  = 4;
  localparam int FAIRB = (NREQ - 1) * MAXB;

  logic clk, rst;
  pipe_rr_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(8)) bus ();

  pipe_rr_arbiter #(.NUM_REQ(NREQ), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_last, pk_pick;
  logic       pk_any;

  pipe_rr_pick #(.NUM_REQ(NREQ)) u_pick (
    .req       (pk_req),
    .last      (pk_last),
    .any_valid (pk_any),
    .pick      (pk_pick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] last;
    logic       any;
    logic [1:0] pick;
  } pick_vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } beat_t;

  int total = 0;
  int bad   = 0;

  // Producer model: each producer holds one presented beat (pv/pd) and a backlog queue.
  logic [3:0] pv;
  logic [7:0] pd [4];
  logic [7:0] pq [4][$];
  beat_t      sb [$];
  int         wcnt [4];
  int         run;
  logic       ordy;
  logic       prev_stall;
  logic [7:0] prev_d;
  logic [1:0] prev_s;
  logic [3:0] last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant_id), NREQ - 1);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_src", 32'(bus.out_src), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    for (int i = 0; i < NREQ; i++) begin
      pq[i].delete();
      pd[i]   = '0;
      wcnt[i] = 0;
    end
    pv = '0;
    sb.delete();
    run = 0;
    prev_stall = 1'b0;
    ordy = 1'b1;
    last_acc = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, then observe 1ns later and update the model.
  task automatic step();
    logic [3:0] acc;
    int nacc;
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (!pv[i] && pq[i].size() > 0) begin
        pv[i] = 1'b1;
        pd[i] = pq[i].pop_front();
      end
    bus.req_valid = pv;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*8 +: 8] = pd[i];
    bus.out_ready = ordy;
    #1;
    chk("req_ready", 32'(bus.req_ready),
        (bus.busy && (!bus.out_valid || bus.out_ready)) ? (32'd1 << bus.grant_id) : 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_data", 32'(bus.out_data), 32'(prev_d));
      chk("hold_src", 32'(bus.out_src), 32'(prev_s));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got data %0h with nothing pending", bus.out_data);
      end else begin
        b = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(b.d));
        chk("out_src", 32'(bus.out_src), 32'(b.s));
      end
    end
    acc  = bus.req_valid & bus.req_ready;
    nacc = $countones(acc);
    run  = bus.busy ? run + nacc : 0;
    if (nacc > 0) chk("burst_len", 32'(run <= MAXB), 1);
    for (int j = 0; j < NREQ; j++) begin
      if (acc[j] || !pv[j]) wcnt[j] = 0;
      else if (nacc > 0) begin
        wcnt[j] += nacc;
        chk("fairness", 32'(wcnt[j] <= FAIRB), 1);
      end
    end
    for (int j = 0; j < NREQ; j++)
      if (acc[j]) begin
        sb.push_back('{d: pd[j], s: 2'(j)});
        pv[j] = 1'b0;
      end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_d     = bus.out_data;
    prev_s     = bus.out_src;
    last_acc   = acc;
  endtask

  task automatic drain();
    bit done;
    ordy = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      done = (sb.size() == 0) && (pv == '0);
      for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) done = 1'b0;
      if (!done) step();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats still pending", sb.size());
    end
  endtask

  pick_vec_t tbl [10];

  initial begin
    int cnt;
    rst = 1'b0;
    pk_req = '0;
    pk_last = '0;

    // Picker vectors: the search starts after 'last', wraps, and gives 'last' the lowest priority.
    tbl[0] = '{4'b0000, 2'd3, 1'b0, 2'd0};
    tbl[1] = '{4'b0001, 2'd3, 1'b1, 2'd0};
    tbl[2] = '{4'b1001, 2'd3, 1'b1, 2'd0};
    tbl[3] = '{4'b1001, 2'd0, 1'b1, 2'd3};
    tbl[4] = '{4'b1111, 2'd1, 1'b1, 2'd2};
    tbl[5] = '{4'b1111, 2'd3, 1'b1, 2'd0};
    tbl[6] = '{4'b0100, 2'd2, 1'b1, 2'd2};
    tbl[7] = '{4'b0110, 2'd0, 1'b1, 2'd1};
    tbl[8] = '{4'b1000, 2'd3, 1'b1, 2'd3};
    tbl[9] = '{4'b0011, 2'd0, 1'b1, 2'd1};
    for (int i = 0; i < 10; i++) begin
      pk_req  = tbl[i].req;
      pk_last = tbl[i].last;
      #1;
      chk("pick_any", 32'(pk_any), 32'(tbl[i].any));
      if (tbl[i].any) chk("pick_idx", 32'(pk_pick), 32'(tbl[i].pick));
    end

    // A single producer streams 8 beats: 4 beats, one bubble, then 4 more.
    do_reset();
    for (int i = 0; i < 8; i++) pq[0].push_back(8'h10 + 8'(i));
    for (int n = 0; n <= 10; n++) begin
      logic ev;
      step();
      ev = (n >= 2 && n <= 5) || (n >= 7 && n <= 10);
      chk("s1_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) chk("s1_data", 32'(bus.out_data), (n <= 5) ? 32'h10 + n - 2 : 32'h14 + n - 7);
      chk("s1_grant", 32'(bus.grant_id), (n == 0) ? 3 : 0);
    end

    // All four producers compete: 4-beat bursts in order 0,1,2,3,0 with one idle cycle between them.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back({2'(i), 6'(k)});
    cnt = 0;
    for (int n = 0; n <= 21; n++) begin
      step();
      chk("s2_acc", 32'(last_acc), (n % 5 == 0) ? 32'd0 : (32'd1 << ((n / 5) % 4)));
      if (n < 20) cnt += $countones(last_acc);
    end
    chk("s2_beats_in_20", 32'(cnt), 16);
    drain();

    // Producer 2 stalled by the consumer for 5 cycles: the output holds, ready drops, no rotation.
    do_reset();
    for (int k = 0; k < 4; k++) pq[2].push_back(8'h20 + 8'(k));
    for (int n = 0; n <= 10; n++) begin
      ordy = !(n >= 2 && n <= 6);
      step();
      if (n == 1) chk("s3_first_acc", 32'(last_acc), 32'b0100);
      if (n >= 2 && n <= 6) begin
        chk("s3_valid", 32'(bus.out_valid), 1);
        chk("s3_data", 32'(bus.out_data), 32'h20);
        chk("s3_ready", 32'(bus.req_ready), 0);
        chk("s3_grant", 32'(bus.grant_id), 2);
      end
      if (n >= 7 && n <= 9) chk("s3_resume_acc", 32'(last_acc), 32'b0100);
      if (n == 10) chk("s3_busy_end", 32'(bus.busy), 0);
    end

    // Producer 1 sends 2 beats and goes idle. The grant moves to 3 for a full 4-beat burst.
    do_reset();
    pq[1].push_back(8'h31);
    pq[1].push_back(8'h32);
    for (int k = 0; k < 4; k++) pq[3].push_back(8'h41 + 8'(k));
    for (int n = 0; n <= 9; n++) begin
      step();
      if (n == 1 || n == 2) chk("s4_p1_acc", 32'(last_acc), 32'b0010);
      if (n == 3) chk("s4_empty_grant", {31'(last_acc), bus.busy}, 1);
      if (n == 4) chk("s4_idle", 32'(bus.busy), 0);
      if (n >= 5 && n <= 8) begin
        chk("s4_p3_acc", 32'(last_acc), 32'b1000);
        chk("s4_grant", 32'(bus.grant_id), 3);
      end
      if (n == 9) chk("s4_busy_end", 32'(bus.busy), 0);
    end

    // Wrap-around: after a burst from producer 3 with 4'b1001 valid, producer 0 is granted next.
    do_reset();
    for (int k = 0; k < 4; k++) pq[3].push_back(8'h50 + 8'(k));
    for (int n = 0; n <= 4; n++) step();
    pq[0].push_back(8'h60);
    pq[0].push_back(8'h61);
    pq[3].push_back(8'h54);
    step();
    chk("s5_idle", 32'(bus.busy), 0);
    step();
    chk("s5_wrap_grant", 32'(bus.grant_id), 0);
    chk("s5_wrap_acc", 32'(last_acc), 32'b0001);
    drain();

    // Reset in the middle of a burst: the in-flight beat is dropped and arbitration restarts at 0.
    do_reset();
    for (int k = 0; k < 8; k++) pq[0].push_back(8'h70 + 8'(k));
    for (int n = 0; n <= 2; n++) step();
    chk("s6_pre_valid", 32'(bus.out_valid), 1);
    do_reset();
    pq[0].push_back(8'h80);
    pq[2].push_back(8'h90);
    step();
    step();
    chk("s6_restart_grant", 32'(bus.grant_id), 0);
    drain();

    // Random traffic with random consumer back-pressure.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int p;
      ordy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) begin
        p = $urandom_range(0, NREQ - 1);
        if (pq[p].size() < 3) pq[p].push_back({2'(p), 6'($urandom_range(0, 63))});
      end
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Shares one downstream consumer (8-bit data_in / valid stream) between NUM_REQ producers using round-robin arbitration with a bounded burst length.
- Sits between N producer instances and one consumer in pipeline tops. Registers the selected beat once, so the consumer sees a single registered valid/data/source stream.
- Guarantees fairness (no requester starved longer than (NUM_REQ-1)*(MAX_BURST+1) granted cycles) and never drops or duplicates a beat.

Parameters:
- NUM_REQ, 4, number of producer ports (2..16).
- DATA_W, 8, beat width in bits.
- MAX_BURST, 4, maximum beats accepted per grant before forced rotation (1..255).
- SRC_W, $clog2(NUM_REQ), derived; width of source ID. Not overridable.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-producer beat valid.
- req_data  input  NUM_REQ*DATA_W  packed producer data; slice i = bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-producer accept. Combinational from state and out_ready.
- out_valid  output  1  registered beat valid to consumer.
- out_data  output  DATA_W  registered beat data.
- out_src  output  SRC_W  index of the producer that sourced out_data.
- out_ready  input  1  consumer accepts the beat.
- busy  output  1  high in GRANT state.
- grant_id  output  SRC_W  currently or last granted requester.

Behaviour:
- Reset values (async assert, sync-safe release):
  - state=IDLE, out_valid=0, out_data=0, out_src=0.
  - grant_id=NUM_REQ-1, so the first arbitration favours requester 0.
  - beat_cnt=0, busy=0.
- Transfer rules:
  - Producer beat transfers when req_valid[i] && req_ready[i].
  - Output beat transfers when out_valid && out_ready.
- Acceptance:
  - can_load = !out_valid || out_ready.
  - req_ready[i] = (state==GRANT) && (grant_id==i) && can_load. All other req_ready bits are 0.
- Output register:
  - On producer accept, out_data, out_src and out_valid load next cycle (latency 1).
  - If out_ready is high and no new accept occurs, out_valid clears.
  - Simultaneous output transfer and new accept gives back-to-back beats with no bubble.
  - out_data and out_src are held stable while out_valid && !out_ready.
- State machine (package enum IDLE, GRANT):
  - IDLE: the picker selects the first requester with req_valid set, searching from grant_id+1 upward with wrap at NUM_REQ-1 to 0.
    - If any valid: grant_id <= pick, beat_cnt <= 0, go to GRANT.
    - If none: stay in IDLE, grant_id unchanged.
  - GRANT, accept this cycle:
    - beat_cnt increments.
    - If beat_cnt == MAX_BURST-1, go to IDLE (burst exhausted).
  - GRANT, no accept and req_valid[grant_id]==0: go to IDLE (requester went idle).
  - GRANT, no accept and req_valid[grant_id]==1 (stalled by consumer): stay in GRANT. Stalls never cause rotation.
- Rotation latency:
  - Exactly one IDLE cycle between consecutive grants.
  - Maximum sustained throughput is MAX_BURST/(MAX_BURST+1) when multiple requesters compete.
  - A single continuously valid requester is re-granted after each IDLE cycle.
- Boundary conditions:
  - MAX_BURST=1: every accepted beat returns to IDLE.
  - beat_cnt width is 8 bits. beat_cnt never exceeds MAX_BURST-1.
  - Wrap-around: grant_id=NUM_REQ-1 searches from 0.
  - Requester dropping valid in the same cycle its grant begins: GRANT sees no valid and returns to IDLE without a transfer.
  - Producers must hold req_valid/req_data until accepted. The arbiter does not check this.
  - Reset mid-burst: out_valid is cleared immediately (async) and the in-flight registered beat is discarded.

Decomposition:
- Package pipe_arb_pkg holds:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e.
  - localparam ARB_BEAT_CNT_W = 8.
- Sub-module pipe_rr_pick: purely combinational rotating-priority picker.
  - Inputs: req vector, last grant index.
  - Outputs: any_valid, pick index.
  - Parameterised on NUM_REQ.
  - Instantiated once, and unit-tested separately.

Test Plan:
- Reset then req_valid=4'b0001, out_ready=1, producer 0 streams 0x10..0x17:
  - grant_id=0 from the second cycle.
  - out_data shows 0x10..0x13, then 1 bubble, then 0x14..0x17.
  - out_src=0 throughout.
- All four requesters continuously valid, out_ready=1:
  - Grant order 0,1,2,3,0.
  - Each burst is 4 beats with 1 idle cycle between bursts.
  - 16 beats in 20 cycles.
- Producer 2 granted, out_ready held 0 for 5 cycles after the first beat:
  - out_valid stays 1 and out_data stays stable.
  - req_ready[2]=0 during the stall.
  - No rotation occurs. Remaining 3 beats follow once out_ready=1.
- Producer 1 sends 2 beats then drops valid, producer 3 is valid:
  - grant moves to 3 after exactly one IDLE cycle.
  - beat_cnt for 3 starts at 0.
- grant_id=3 (after a burst), req_valid=4'b1001:
  - next grant is 0 (wrap-around), not 3.
- rst asserted mid-burst with out_valid=1:
  - out_valid=0, busy=0, grant_id=3 on the same edge.
  - After deassert, arbitration restarts, favouring requester 0.
